// File: rtl/control_exec_mc.sv
// Multi-cycle execute-stage controller: decodes one opcode per handshake, sequences
// ALU/writeback enables and memory strobes with a wait-state timeout and sticky halt.
module control_exec_mc #(
    parameter int unsigned OPC_W       = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned WAIT_W      = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [OPC_W-1:0] instr,
    input  logic             instr_valid,
    output logic             exec_ready,
    input  logic             flush,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mdr_load,
    output logic             ir3_load,
    output logic             flag_write,
    output logic             alu_out_write,
    output logic [2:0]       alu_2,
    output logic [2:0]       alu_op,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StMem,
        StHalt
    } state_e;

    typedef enum logic [2:0] {
        ClsNop,
        ClsAlu,
        ClsLoad,
        ClsStore,
        ClsStop
    } cls_e;

    localparam logic [2:0] SelR2   = 3'd0;
    localparam logic [2:0] SelImm5 = 3'd3;
    localparam logic [2:0] SelImm3 = 3'd4;

    localparam logic [2:0] OpAdd   = 3'd0;
    localparam logic [2:0] OpSub   = 3'd1;
    localparam logic [2:0] OpOr    = 3'd2;
    localparam logic [2:0] OpNand  = 3'd3;
    localparam logic [2:0] OpShift = 3'd4;

    localparam bit              TimeoutEn = (MEM_TIMEOUT != 0);
    localparam logic [WAIT_W-1:0] WaitLast = WAIT_W'(MEM_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic               is_alu_q, is_alu_d;
    logic               is_load_q, is_load_d;
    logic [2:0]         alu_2_q, alu_2_d;
    logic [2:0]         alu_op_q, alu_op_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               halted_q, halted_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   retire_q;

    logic [3:0]         opc;
    cls_e               dec_cls;
    logic [2:0]         dec_alu_2;
    logic [2:0]         dec_alu_op;
    logic               accept;

    assign opc = instr[3:0];

    // The low-three-bit patterns (shift, ori) win over the full-opcode matches.
    always_comb begin
        dec_cls    = ClsNop;
        dec_alu_2  = SelR2;
        dec_alu_op = OpOr;
        if (opc[2:0] == 3'd3) begin
            dec_cls    = ClsAlu;
            dec_alu_2  = SelImm3;
            dec_alu_op = OpShift;
        end else if (opc[2:0] == 3'd7) begin
            dec_cls    = ClsAlu;
            dec_alu_2  = SelImm5;
            dec_alu_op = OpOr;
        end else begin
            unique case (opc)
                4'd4: begin
                    dec_cls    = ClsAlu;
                    dec_alu_op = OpAdd;
                end
                4'd6: begin
                    dec_cls    = ClsAlu;
                    dec_alu_op = OpSub;
                end
                4'd8: begin
                    dec_cls    = ClsAlu;
                    dec_alu_op = OpNand;
                end
                4'd0:    dec_cls = ClsLoad;
                4'd2:    dec_cls = ClsStore;
                4'd1:    dec_cls = ClsStop;
                default: dec_cls = ClsNop;
            endcase
        end
    end

    assign exec_ready = (state_q == StIdle) || (state_q == StExec);
    assign accept     = instr_valid && exec_ready && !flush;

    always_comb begin
        state_d       = state_q;
        is_alu_d      = is_alu_q;
        is_load_d     = is_load_q;
        alu_2_d       = alu_2_q;
        alu_op_d      = alu_op_q;
        wait_d        = wait_q;
        halted_d      = halted_q;
        timeout_d     = timeout_q;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mdr_load      = 1'b0;
        ir3_load      = 1'b0;
        flag_write    = 1'b0;
        alu_out_write = 1'b0;

        unique case (state_q)
            StIdle: begin
            end
            StExec: begin
                state_d = StIdle;
                if (!flush) begin
                    ir3_load      = 1'b1;
                    alu_out_write = is_alu_q;
                    flag_write    = is_alu_q;
                end
            end
            StMem: begin
                // flush is deliberately ignored: the bus transaction must finish or time out.
                mem_read  = is_load_q;
                mem_write = !is_load_q;
                if (mem_ready) begin
                    ir3_load = 1'b1;
                    mdr_load = is_load_q;
                    state_d  = StIdle;
                end else if (TimeoutEn && (wait_q == WaitLast)) begin
                    timeout_d = 1'b1;
                    halted_d  = 1'b1;
                    state_d   = StHalt;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            StHalt: begin
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            alu_2_d   = dec_alu_2;
            alu_op_d  = dec_alu_op;
            is_alu_d  = (dec_cls == ClsAlu);
            is_load_d = (dec_cls == ClsLoad);
            unique case (dec_cls)
                ClsLoad, ClsStore: begin
                    state_d = StMem;
                    wait_d  = '0;
                end
                ClsStop: begin
                    state_d  = StHalt;
                    halted_d = 1'b1;
                end
                default: state_d = StExec;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            is_alu_q  <= 1'b0;
            is_load_q <= 1'b0;
            alu_2_q   <= '0;
            alu_op_q  <= '0;
            wait_q    <= '0;
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
            retire_q  <= '0;
        end else begin
            state_q   <= state_d;
            is_alu_q  <= is_alu_d;
            is_load_q <= is_load_d;
            alu_2_q   <= alu_2_d;
            alu_op_q  <= alu_op_d;
            wait_q    <= wait_d;
            halted_q  <= halted_d;
            timeout_q <= timeout_d;
            if (ir3_load) begin
                retire_q <= retire_q + CNT_W'(1);
            end
        end
    end

    assign alu_2       = alu_2_q;
    assign alu_op      = alu_op_q;
    assign halted      = halted_q;
    assign mem_timeout = timeout_q;
    assign retire_cnt  = retire_q;

endmodule
